// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU emitting its WIDTH-bit result LSB-first on dout, then a done pulse and carry.
// Define SERIAL_ALU_PARITY_EN to append one even-parity bit after the result.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             cin,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_ALU_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0] mode_q;
  logic [CW-1:0] cnt;
  logic start_q, carry, trig, arith, bb, res, carry_n, last;
  always_comb begin
    state_d = state_q;
    // busy still high during the done cycle blocks an early retrigger
    trig = start & ~start_q & ~busy & (state_q == IDLE);
    arith = mode_q[2:1] == 2'b00;
    bb = b_q[0] ^ (mode_q == 3'b001);
    res = arith             ? a_q[0] ^ bb ^ carry :
          mode_q == 3'b010  ? a_q[0] & b_q[0] :
          mode_q == 3'b011  ? a_q[0] | b_q[0] :
          mode_q == 3'b100  ? a_q[0] ^ b_q[0] :
          mode_q == 3'b101  ? a_q[0] :
          mode_q == 3'b110  ? b_q[0] : ~a_q[0];
    carry_n = arith & ((a_q[0] & bb) | (carry & (a_q[0] ^ bb)));
    last = cnt == CW'(WIDTH - 1);
    case (state_q)
      IDLE:   state_d = trig ? SHIFT : IDLE;
`ifdef SERIAL_ALU_PARITY_EN
      SHIFT:  state_d = last ? PARITY : SHIFT;
      PARITY: state_d = DONE;
`else
      SHIFT:  state_d = last ? DONE : SHIFT;
`endif
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cout       <= 1'b0;
`ifdef SERIAL_ALU_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      start_q <= start;
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (trig) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            carry  <= (mode == 3'b000) ? cin : (mode == 3'b001);
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef SERIAL_ALU_PARITY_EN
            par    <= 1'b0;
`endif
          end else if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          dout       <= res;
          dout_valid <= 1'b1;
          carry      <= carry_n;
          a_q        <= a_q >> 1;
          b_q        <= b_q >> 1;
          cnt        <= cnt + 1'b1;
`ifdef SERIAL_ALU_PARITY_EN
          par        <= par ^ res;
`endif
        end
`ifdef SERIAL_ALU_PARITY_EN
        PARITY: begin
          dout       <= par;
          dout_valid <= 1'b1;
        end
`endif
        DONE: begin
          done       <= 1'b1;
          dout_valid <= 1'b0;
          cout       <= carry;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: randomized and directed checks of serial_alu against an arithmetic reference model.
module tb_serial_alu;
  localparam int W = 8;
`ifdef SERIAL_ALU_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] mode = '0;
  logic dout, dout_valid, busy, done, cout;
  int n_vec = 0, n_err = 0;
  int nb, nd;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .mode(mode), .cin(cin),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {carry, result} from plain arithmetic on whole words
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [2:0] m, input logic c);
    case (m)
      3'd0: return {1'b0, x} + {1'b0, y} + (W+1)'(c);
      3'd1: return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      3'd2: return {1'b0, x & y};
      3'd3: return {1'b0, x | y};
      3'd4: return {1'b0, x ^ y};
      3'd5: return {1'b0, x};
      3'd6: return {1'b0, y};
      default: return {1'b0, ~x};
    endcase
  endfunction

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] m, input logic c);
    logic [W:0] e;
    e = model(x, y, m, c);
    @(negedge clk);
    a = x; b = y; mode = m; cin = c; start = 1'b1;
    @(negedge clk);
    chk("busy_on", busy, 1);
    chk("idle_valid", dout_valid, 0);
    start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 3'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("valid[%0d]", i), dout_valid, 1);
      chk($sformatf("bit[%0d] m%0d", i, m), dout, e[i]);
      chk("early_done", done, 0);
    end
`ifdef SERIAL_ALU_PARITY_EN
    @(negedge clk);
    chk("par_valid", dout_valid, 1);
    chk("parity", dout, ^e[W-1:0]);
`endif
    @(negedge clk);
    chk("done", done, 1);
    chk("end_valid", dout_valid, 0);
    chk($sformatf("cout m%0d", m), cout, e[W]);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("busy_off", busy, 0);
  endtask

  task automatic pattern(input int hold_to, input int pulse_at, output int busy_n, output int done_n);
    busy_n = 0; done_n = 0;
    a = 8'h12; b = 8'h34; mode = 3'd0; cin = 1'b0;
    for (int k = 0; k < 30; k++) begin
      start = (k < hold_to) || (k == pulse_at);
      @(negedge clk);
      busy_n += int'(busy);
      done_n += int'(done);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    run(8'd5, 8'd3, 3'd0, 1'b1);
    run(8'd3, 8'd5, 3'd1, 1'b1);
    run(8'd5, 8'd3, 3'd1, 1'b1);
    run(8'hFF, 8'h01, 3'd0, 1'b0);
    // abort in the third SHIFT cycle; cout is 1 from the previous add
    @(negedge clk);
    a = 8'h77; b = 8'h11; mode = 3'd0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", dout, 0);
    chk("abort_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hA5, 8'hFF, 3'd4, 1'b0);
    pattern(20, -1, nb, nd);
    chk("hold_busy_cycles", nb, W + 2 + P);
    chk("hold_done_count", nd, 1);
    pattern(1, 4, nb, nd);
    chk("pulse_busy_cycles", nb, W + 2 + P);
    chk("pulse_done_count", nd, 1);
    // start already high when reset releases counts as a trigger
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_trigger", busy, 1);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("release_drained", busy, 0);
    for (int t = 0; t < 40; t++)
      run(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
